// File: rtl/param_switch_core.sv
// N-port switch core: per-output FIFOs fed by round-robin arbitration, plus an illegal-address drop counter.
// Latency 2 cycles input to output; in_rdy drops for a losing or full-blocked input, and illegal flits are always consumed.

// Generic circular FIFO: registered count, power-of-2 depth, head visible combinationally.
// Latency: a push at edge T is readable after T; a pop at T advances the head after T.
// Backpressure: push is ignored when full and pop is ignored when empty.
module sw_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module param_switch_core #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
    input  logic [NUM_PORTS-1:0]          valid_in,
    output logic [NUM_PORTS-1:0]          in_rdy,
    output logic [NUM_PORTS*ADDR_W-1:0]   addr_out,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [NUM_PORTS-1:0]          valid_out,
    output logic [NUM_PORTS-1:0]          rcv_rdy,
    input  logic [NUM_PORTS-1:0]          data_rd,
    output logic [CNT_W-1:0]              drop_cnt
);
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int EW   = ADDR_W + DATA_W;
    localparam int CMPW = ADDR_W + 8;

    logic [NUM_PORTS-1:0]                 illegal;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  req;      // req[output][input]
    logic [NUM_PORTS-1:0][PW-1:0]         rr, win;
    logic [NUM_PORTS-1:0]                 found, push, pop, full, empty;
    logic [NUM_PORTS-1:0][EW-1:0]         head, push_dat;
    logic [PW:0]                          ndrop;
    logic [CNT_W:0]                       drop_sum;

    always_comb begin
        illegal = '0;
        req     = '0;
        ndrop   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (valid_in[k] && (CMPW'(addr_in[k*ADDR_W +: ADDR_W]) >= CMPW'(NUM_PORTS)))
                illegal[k] = 1'b1;
            ndrop = ndrop + (PW+1)'(illegal[k]);
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (valid_in[k] && (CMPW'(addr_in[k*ADDR_W +: ADDR_W]) == CMPW'(j)))
                    req[j][k] = 1'b1;
            end
        end
    end

    // Scan inputs starting at rr[j]; fullness uses the registered count only.
    always_comb begin
        found    = '0;
        win      = '0;
        push     = '0;
        push_dat = '0;
        in_rdy   = ~valid_in | illegal;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                logic [PW:0] idx;
                idx = {1'b0, rr[j]} + (PW+1)'(i);
                if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
                if (!found[j] && req[j][idx[PW-1:0]]) begin
                    found[j] = 1'b1;
                    win[j]   = idx[PW-1:0];
                end
            end
            push[j]     = found[j] & ~full[j];
            push_dat[j] = {addr_in[win[j]*ADDR_W +: ADDR_W], data_in[win[j]*DATA_W +: DATA_W]};
            if (push[j]) in_rdy[win[j]] = 1'b1;
        end
    end

    assign pop      = data_rd & ~empty;
    assign rcv_rdy  = ~empty;
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(ndrop);

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        sw_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[j]),
            .push_dat (push_dat[j]),
            .pop      (pop[j]),
            .head     (head[j]),
            .full     (full[j]),
            .empty    (empty[j])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr        <= '0;
            drop_cnt  <= '0;
            valid_out <= '0;
            addr_out  <= '0;
            data_out  <= '0;
        end else begin
            drop_cnt  <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            valid_out <= pop;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (push[j])
                    rr[j] <= (win[j] == PW'(NUM_PORTS - 1)) ? '0 : win[j] + PW'(1);
                if (pop[j]) begin
                    addr_out[j*ADDR_W +: ADDR_W] <= head[j][EW-1 -: ADDR_W];
                    data_out[j*DATA_W +: DATA_W] <= head[j][DATA_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_param_switch_core.sv
// Directed bench for param_switch_core at NUM_PORTS=4, 8-bit addr/data, depth 4, 16-bit drop counter.
module tb_param_switch_core;
    logic        clk;
    logic        reset;
    logic [31:0] addr_in, data_in, addr_out, data_out;
    logic [3:0]  valid_in, in_rdy, valid_out, rcv_rdy, data_rd;
    logic [15:0] drop_cnt;
    int          total, bad;

    param_switch_core #(.NUM_PORTS(4), .DATA_W(8), .ADDR_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .in_rdy    (in_rdy),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .rcv_rdy   (rcv_rdy),
        .data_rd   (data_rd),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic [7:0] a, input logic [7:0] d, input logic v);
        addr_in[k*8 +: 8] = a;
        data_in[k*8 +: 8] = d;
        valid_in[k]       = v;
    endtask

    task automatic test_reset();
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL reset_rcv_rdy: got %b want 0000", rcv_rdy); end
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL reset_valid_out: got %b want 0000", valid_out); end
        total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
        total++; if ({addr_out, data_out} !== 64'h0) begin bad++; $display("FAIL reset_outputs: got %h_%h want 0", addr_out, data_out); end
        total++; if (in_rdy !== 4'b1111) begin bad++; $display("FAIL reset_in_rdy: got %b want 1111", in_rdy); end
    endtask

    task automatic test_single();
        set_in(0, 8'h02, 8'hA5, 1'b1);
        data_rd = 4'b0100;
        #1;
        total++; if (in_rdy !== 4'b1111) begin bad++; $display("FAIL single_in_rdy: got %b want 1111", in_rdy); end
        tick();
        set_in(0, 8'h02, 8'hA5, 1'b0);
        #1;
        total++; if (rcv_rdy !== 4'b0100) begin bad++; $display("FAIL single_rcv_rdy: got %b want 0100", rcv_rdy); end
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL single_early_valid: got %b want 0000", valid_out); end
        tick();
        total++; if (valid_out !== 4'b0100) begin bad++; $display("FAIL single_valid_out: got %b want 0100", valid_out); end
        total++; if (addr_out !== 32'h0002_0000) begin bad++; $display("FAIL single_addr_out: got %h want 00020000", addr_out); end
        total++; if (data_out !== 32'h00A5_0000) begin bad++; $display("FAIL single_data_out: got %h want 00a50000", data_out); end
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL single_drained: got %b want 0000", rcv_rdy); end
        tick();
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL single_one_pulse: got %b want 0000", valid_out); end
        total++; if (data_out !== 32'h00A5_0000) begin bad++; $display("FAIL single_hold: got %h want 00a50000", data_out); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_rdy [6];
        logic [7:0] exp_d [6];
        exp_rdy = '{4'b0101, 4'b0110, 4'b1100, 4'b0101, 4'b0110, 4'b1100};
        exp_d   = '{8'h10, 8'h11, 8'h13, 8'h10, 8'h11, 8'h13};
        data_rd = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            set_in(0, 8'h01, 8'h10, c < 6);
            set_in(1, 8'h01, 8'h11, c < 6);
            set_in(3, 8'h01, 8'h13, c < 6);
            #1;
            if (c < 6) begin
                total++;
                if (in_rdy !== exp_rdy[c]) begin bad++; $display("FAIL contention_grant[%0d]: got %b want %b", c, in_rdy, exp_rdy[c]); end
            end
            if (c >= 2) begin
                total++;
                if (valid_out !== 4'b0010 || data_out[15:8] !== exp_d[c-2] || addr_out[15:8] !== 8'h01) begin
                    bad++;
                    $display("FAIL contention_data[%0d]: got v=%b a=%h d=%h want v=0010 a=01 d=%h",
                             c - 2, valid_out, addr_out[15:8], data_out[15:8], exp_d[c-2]);
                end
            end
            tick();
        end
        total++; if (valid_out !== 4'b0000 || rcv_rdy !== 4'b0000) begin bad++; $display("FAIL contention_idle: got v=%b r=%b want 0000 0000", valid_out, rcv_rdy); end
    endtask

    task automatic test_full();
        logic [7:0] got [$];
        int         nxt;
        logic       acc;
        data_rd = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set_in(2, 8'h00, 8'(8'h20 + i), 1'b1);
            #1;
            total++; if (in_rdy[2] !== 1'b1) begin bad++; $display("FAIL full_fill[%0d]: got %b want 1", i, in_rdy[2]); end
            tick();
        end
        set_in(2, 8'h00, 8'h24, 1'b1);
        #1;
        total++; if (in_rdy[2] !== 1'b0) begin bad++; $display("FAIL full_block: got %b want 0", in_rdy[2]); end
        total++; if (rcv_rdy[0] !== 1'b1) begin bad++; $display("FAIL full_rcv_rdy: got %b want 1", rcv_rdy[0]); end
        data_rd = 4'b0001;
        #1;
        total++; if (in_rdy[2] !== 1'b0) begin bad++; $display("FAIL full_read_no_push: got %b want 0", in_rdy[2]); end
        nxt = 4;
        tick();
        if (valid_out[0]) got.push_back(data_out[7:0]);
        for (int cyc = 0; cyc < 16; cyc++) begin
            set_in(2, 8'h00, 8'(8'h20 + nxt), nxt < 6);
            #1;
            acc = (nxt < 6) && in_rdy[2];
            tick();
            if (acc) nxt++;
            if (valid_out[0]) got.push_back(data_out[7:0]);
        end
        set_in(2, 8'h00, 8'h00, 1'b0);
        total++; if (got.size() != 6) begin bad++; $display("FAIL full_count: got %0d flits want 6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            total++;
            if (got[i] !== 8'(8'h20 + i)) begin bad++; $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 8'(8'h20 + i)); end
        end
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL full_drained: got %b want 0000", rcv_rdy); end
    endtask

    task automatic test_illegal();
        data_rd = 4'b0000;
        set_in(0, 8'h07, 8'h55, 1'b1);
        set_in(3, 8'h07, 8'h66, 1'b1);
        #1;
        total++; if (in_rdy !== 4'b1111) begin bad++; $display("FAIL illegal_in_rdy: got %b want 1111", in_rdy); end
        tick();
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL illegal_count2: got %h want 0002", drop_cnt); end
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL illegal_no_fifo: got %b want 0000", rcv_rdy); end
        repeat (16'h7FFE) tick();
        total++; if (drop_cnt !== 16'hFFFE) begin bad++; $display("FAIL illegal_near_sat: got %h want fffe", drop_cnt); end
        tick();
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL illegal_saturate: got %h want ffff", drop_cnt); end
        tick();
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL illegal_stay_sat: got %h want ffff", drop_cnt); end
        set_in(0, 8'h00, 8'h00, 1'b0);
        set_in(3, 8'h00, 8'h00, 1'b0);
        #1;
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL illegal_fifos_empty: got %b want 0000", rcv_rdy); end
    endtask

    task automatic test_parallel();
        data_rd = 4'b0000;
        for (int k = 0; k < 4; k++) set_in(k, 8'(3 - k), 8'(8'h30 + k), 1'b1);
        #1;
        total++; if (in_rdy !== 4'b1111) begin bad++; $display("FAIL parallel_in_rdy: got %b want 1111", in_rdy); end
        tick();
        valid_in = 4'b0000;
        #1;
        total++; if (rcv_rdy !== 4'b1111) begin bad++; $display("FAIL parallel_rcv_rdy: got %b want 1111", rcv_rdy); end
        data_rd = 4'b1111;
        tick();
        total++; if (valid_out !== 4'b1111) begin bad++; $display("FAIL parallel_valid_out: got %b want 1111", valid_out); end
        total++; if (addr_out !== 32'h0302_0100) begin bad++; $display("FAIL parallel_addr_out: got %h want 03020100", addr_out); end
        total++; if (data_out !== 32'h3031_3233) begin bad++; $display("FAIL parallel_data_out: got %h want 30313233", data_out); end
        tick();
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL parallel_empty_read: got %b want 0000", valid_out); end
        total++; if (data_out !== 32'h3031_3233 || rcv_rdy !== 4'b0000) begin bad++; $display("FAIL parallel_hold: got d=%h r=%b want 30313233 0000", data_out, rcv_rdy); end
        data_rd = 4'b0000;
    endtask

    task automatic test_reset_mid();
        data_rd = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 8'h01, 8'(8'h41 + i), 1'b1);
            #1;
            total++; if (in_rdy[1] !== 1'b1) begin bad++; $display("FAIL rst_fill[%0d]: got %b want 1", i, in_rdy[1]); end
            tick();
        end
        set_in(1, 8'h01, 8'h00, 1'b0);
        data_rd = 4'b0010;
        #1;
        total++; if (rcv_rdy !== 4'b0010) begin bad++; $display("FAIL rst_pre_rcv: got %b want 0010", rcv_rdy); end
        tick();
        total++; if (valid_out !== 4'b0010 || data_out[15:8] !== 8'h41) begin bad++; $display("FAIL rst_pre_pop: got v=%b d=%h want 0010 41", valid_out, data_out[15:8]); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (rcv_rdy !== 4'b0000 || valid_out !== 4'b0000) begin bad++; $display("FAIL rst_async_flags: got r=%b v=%b want 0000 0000", rcv_rdy, valid_out); end
        total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL rst_async_drop: got %h want 0000", drop_cnt); end
        total++; if ({addr_out, data_out} !== 64'h0) begin bad++; $display("FAIL rst_async_data: got %h_%h want 0", addr_out, data_out); end
        #1;
        reset = 1'b1;
        tick();
        total++; if (rcv_rdy !== 4'b0000) begin bad++; $display("FAIL rst_post_rcv: got %b want 0000", rcv_rdy); end
        tick();
        total++; if (valid_out !== 4'b0000) begin bad++; $display("FAIL rst_post_read: got %b want 0000", valid_out); end
        data_rd = 4'b0000;
        set_in(0, 8'h01, 8'h50, 1'b1);
        set_in(3, 8'h01, 8'h53, 1'b1);
        #1;
        total++; if (in_rdy !== 4'b0111) begin bad++; $display("FAIL rst_rr_pointer: got %b want 0111", in_rdy); end
        tick();
        valid_in = 4'b0000;
        data_rd  = 4'b0010;
        tick();
        total++; if (valid_out !== 4'b0010 || data_out[15:8] !== 8'h50) begin bad++; $display("FAIL rst_rr_winner: got v=%b d=%h want 0010 50", valid_out, data_out[15:8]); end
        data_rd = 4'b0000;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        addr_in  = '0;
        data_in  = '0;
        valid_in = '0;
        data_rd  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        tick();
        test_single();
        test_contention();
        test_full();
        test_illegal();
        test_parallel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
